chunked_mag_comparator: RTL and testbench
=========================================

Name: chunked_mag_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, in unsigned or two's-complement mode.
- Compares CHUNK bits per cycle, MSB chunk first.
- Uses a valid/ready handshake on input and output.
- Produces one-hot a_grt / b_grt / a_eq_b.
- Replaces the fixed 2-bit combinational comparator wherever wide operands must be compared without a long carry-style compare chain on the critical path.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK
CHUNK, 4, bits compared per cycle; 1..WIDTH
NCHUNK, WIDTH/CHUNK, derived localparam; not overridable
CW, $clog2(NCHUNK+1), derived width of cmp_cycles

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and mode valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with operands
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
a_grt  output  1  A > B
b_grt  output  1  B > A
a_eq_b  output  1  A == B
cmp_cycles  output  CW  number of compare cycles spent on this result
busy  output  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - out_valid, a_grt, b_grt, a_eq_b, cmp_cycles and busy are 0.
  - in_ready is 0 while rst_n is low, then 1 from the first cycle after release.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch a and b. If signed_mode = 1, invert bit WIDTH-1 of both latched operands (offset-binary mapping).
  - Set idx = NCHUNK-1, clear the decision register and cmp_cycles, then go to CMP.
- CMP: in_ready = 0. Each cycle:
  - Compare chunk idx of both operands unsigned, and increment cmp_cycles.
  - If the chunks differ and no decision is recorded yet, record GT or LT.
  - Exit to DONE when the required condition holds (see Optional Feature) or when idx == 0; otherwise decrement idx.
  - If no decision is recorded at exit, the result is EQ.
- Result registers: a_grt, b_grt, a_eq_b and cmp_cycles are loaded on the edge entering DONE. Exactly one of the three flags is 1 while out_valid = 1.
- DONE:
  - out_valid = 1; all outputs are held stable.
  - in_valid is ignored.
  - On out_ready = 1, go to IDLE and clear out_valid and the result flags on that edge. in_ready returns 1 the following cycle; there is no same-cycle turnaround.
- Latency: out_valid rises exactly cmp_cycles clock edges after the accept edge.
  - Minimum 1 cycle (early exit on the MSB chunk).
  - Maximum NCHUNK cycles.
- out_ready may be high before out_valid; it has no effect outside DONE.
- Reset mid-operation: asynchronous return to IDLE, all outputs to reset values, latched operands discarded; no result is emitted.
- Degenerate case CHUNK == WIDTH: single-cycle CMP, cmp_cycles is always 1.

Optional Feature:
Macro COMPARATOR_EARLY_EXIT_EN.
- Defined: CMP exits to DONE in the first cycle that records a decision. Latency depends on the data.
- Undefined: CMP always runs all NCHUNK cycles, and the first recorded decision is kept (sticky). Latency and cmp_cycles are constant at NCHUNK, which suits timing-leak-free use.
- Result flags are identical in both builds.

Decomposition:
- Package comparator_pkg holds:
  - typedef enum state_t {IDLE, CMP, DONE}
  - typedef enum result_t {RES_EQ, RES_GT, RES_LT}
  - the WIDTH % CHUNK legality check, as a function used in an elaboration-time assertion
- Sub-module cmp_chunk: combinational, parametrised by CHUNK, inputs x and y, outputs gt and lt. It is the generalised per-chunk equivalent of the 2-bit comparator.

Test Plan (WIDTH=16, CHUNK=4, macro defined unless noted):
1. a=0x1234, b=0x1234, unsigned -> a_eq_b=1, cmp_cycles=4, out_valid 4 edges after accept.
2. a=0x8000, b=0x7FFF, unsigned -> a_grt=1, cmp_cycles=1. Same operands with signed_mode=1 -> b_grt=1, cmp_cycles=1.
3. a=0x1235, b=0x1234, unsigned -> a_grt=1, cmp_cycles=4. a=0xFFFE, b=0xFFFF, signed -> b_grt=1.
4. Hold out_ready=0 for 5 cycles while pulsing in_valid with new operands -> outputs stable, in_ready=0, new operands not accepted. Then out_ready=1 for one cycle -> out_valid=0 next edge, in_ready=1 the edge after.
5. Assert rst_n=0 during the 2nd CMP cycle of a 0x1234 vs 0x1234 compare -> outputs 0 immediately, no out_valid after release. The next transaction, 0x0001 vs 0x0002, gives b_grt=1.
6. Macro undefined: a=0x8000, b=0x7FFF, unsigned -> a_grt=1, cmp_cycles=4, latency 4.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared types and configuration check for the chunked magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_EQ = 2'd0,
        RES_GT = 2'd1,
        RES_LT = 2'd2
    } result_t;

    // Operand width must split into a whole number of non-empty chunks.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Unsigned compare of one CHUNK-bit slice; generalisation of the 2-bit comparator.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    output logic             gt,
    output logic             lt
);

    // Per-chunk relation; equality is implied when neither flag is set.
    always_comb begin
        gt = (x > y);
        lt = (x < y);
    end

endmodule

// File: rtl/chunked_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, MSB chunk first, valid/ready on both sides.
// Optional build macro COMPARATOR_EARLY_EXIT_EN stops on the first differing chunk.
module chunked_mag_comparator
    import comparator_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_grt,
    output logic             b_grt,
    output logic             a_eq_b,
    output logic [CW-1:0]    cmp_cycles,
    output logic             busy
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $fatal(1, "chunked_mag_comparator: WIDTH must be a multiple of CHUNK");
    end

    state_t           state_r;
    result_t          dec_r;
    result_t          dec_next_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [IW-1:0]    idx_r;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_next_s;
    logic [WIDTH-1:0] sign_flip_s;
    logic [CHUNK-1:0] chunk_a_s;
    logic [CHUNK-1:0] chunk_b_s;
    logic             gt_s;
    logic             lt_s;
    logic             exit_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             a_grt_r;
    logic             b_grt_r;
    logic             a_eq_b_r;
    logic [CW-1:0]    cmp_cycles_r;
    logic             busy_r;

    // Flipping the sign bit maps two's complement onto offset binary, so the
    // chunk datapath only ever needs an unsigned compare.
    always_comb begin
        sign_flip_s            = {WIDTH{1'b0}};
        sign_flip_s[WIDTH-1]   = signed_mode;
    end

    // Select the chunk currently under comparison.
    always_comb begin
        chunk_a_s = CHUNK'(a_r >> (int'(idx_r) * CHUNK));
        chunk_b_s = CHUNK'(b_r >> (int'(idx_r) * CHUNK));
    end

    cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
        .x  (chunk_a_s),
        .y  (chunk_b_s),
        .gt (gt_s),
        .lt (lt_s)
    );

    // First differing chunk decides; later chunks never override it.
    always_comb begin
        dec_next_s = dec_r;
        if (dec_r == RES_EQ) begin
            if (gt_s) begin
                dec_next_s = RES_GT;
            end else if (lt_s) begin
                dec_next_s = RES_LT;
            end else begin
                dec_next_s = RES_EQ;
            end
        end else begin
            dec_next_s = dec_r;
        end
        cnt_next_s = cnt_r + CW'(1);
`ifdef COMPARATOR_EARLY_EXIT_EN
        exit_s = (idx_r == {IW{1'b0}}) || (dec_next_s != RES_EQ);
`else
        exit_s = (idx_r == {IW{1'b0}});
`endif
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            dec_r        <= RES_EQ;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            idx_r        <= {IW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            a_grt_r      <= 1'b0;
            b_grt_r      <= 1'b0;
            a_eq_b_r     <= 1'b0;
            cmp_cycles_r <= {CW{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r          <= a ^ sign_flip_s;
                        b_r          <= b ^ sign_flip_s;
                        idx_r        <= IW'(NCHUNK - 1);
                        dec_r        <= RES_EQ;
                        cnt_r        <= {CW{1'b0}};
                        cmp_cycles_r <= {CW{1'b0}};
                        in_ready_r   <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= CMP;
                    end else begin
                        in_ready_r   <= 1'b1;
                    end
                end
                CMP: begin
                    cnt_r <= cnt_next_s;
                    dec_r <= dec_next_s;
                    if (exit_s) begin
                        out_valid_r  <= 1'b1;
                        a_grt_r      <= (dec_next_s == RES_GT);
                        b_grt_r      <= (dec_next_s == RES_LT);
                        a_eq_b_r     <= (dec_next_s == RES_EQ);
                        cmp_cycles_r <= cnt_next_s;
                        state_r      <= DONE;
                    end else begin
                        idx_r        <= idx_r - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        a_grt_r     <= 1'b0;
                        b_grt_r     <= 1'b0;
                        a_eq_b_r    <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    a_grt_r     <= 1'b0;
                    b_grt_r     <= 1'b0;
                    a_eq_b_r    <= 1'b0;
                    in_ready_r  <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign a_grt      = a_grt_r;
    assign b_grt      = b_grt_r;
    assign a_eq_b     = a_eq_b_r;
    assign cmp_cycles = cmp_cycles_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_chunked_mag_comparator.sv
// Randomised and directed self-checking bench for chunked_mag_comparator (WIDTH=16, CHUNK=4).
module tb_chunked_mag_comparator;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NC = W / C;
`ifdef COMPARATOR_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         signed_mode;
    logic         out_valid;
    logic         out_ready;
    logic         a_grt;
    logic         b_grt;
    logic         a_eq_b;
    logic [2:0]   cmp_cycles;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    chunked_mag_comparator #(.WIDTH(W), .CHUNK(C)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a_grt       (a_grt),
        .b_grt       (b_grt),
        .a_eq_b      (a_eq_b),
        .cmp_cycles  (cmp_cycles),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer compare; cycle count from the highest differing bit.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input bit s,
                                  output logic [2:0] flags, output int cyc);
        logic [W-1:0] d;
        int p;
        if (s) begin
            if ($signed(x) > $signed(y))      flags = 3'b100;
            else if ($signed(x) < $signed(y)) flags = 3'b010;
            else                              flags = 3'b001;
        end else begin
            if (x > y)      flags = 3'b100;
            else if (x < y) flags = 3'b010;
            else            flags = 3'b001;
        end
        d   = x ^ y;
        cyc = NC;
        if (EARLY) begin
            p = -1;
            for (int i = 0; i < W; i++) if (d[i]) p = i;
            if (p >= 0) cyc = (W - 1 - p) / C + 1;
        end
    endfunction

    task automatic drive_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input bit s,
                            input bit pre_ready, input bit hold,
                            output logic [2:0] r_flags, output int r_cyc, output int r_lat,
                            output bit timeout);
        int w;
        timeout = 1'b0;
        r_flags = 3'b000;
        r_cyc   = 0;
        r_lat   = 0;
        w       = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        a = oa; b = ob; signed_mode = s; in_valid = 1'b1; out_ready = pre_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!out_valid && r_lat < NC + 4) begin
            @(posedge clk); #1; r_lat++;
        end
        if (!out_valid) begin
            timeout   = 1'b1;
            out_ready = 1'b0;
            return;
        end
        r_flags = {a_grt, b_grt, a_eq_b};
        r_cyc   = int'(cmp_cycles);
        if (!hold) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        #2;
        n_checks++;
        if ({out_valid, a_grt, b_grt, a_eq_b, cmp_cycles, busy, in_ready} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected 000000000",
                     {out_valid, a_grt, b_grt, a_eq_b, cmp_cycles, busy, in_ready});
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [5] = '{16'h1234, 16'h8000, 16'h8000, 16'h1235, 16'hFFFE};
        logic [W-1:0] vb [5] = '{16'h1234, 16'h7FFF, 16'h7FFF, 16'h1234, 16'hFFFF};
        bit           vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0] fl, ef;
        int cy, lat, ecy;
        bit to;
        for (int i = 0; i < 5; i++) begin
            model(va[i], vb[i], vs[i], ef, ecy);
            drive_op(va[i], vb[i], vs[i], 1'b0, 1'b0, fl, cy, lat, to);
            n_checks++;
            if (to || fl !== ef || cy != ecy || lat != ecy) begin
                n_fail++;
                $display("FAIL directed_%0d: got flags=%b cyc=%0d lat=%0d to=%0d expected flags=%b cyc=%0d lat=%0d",
                         i, fl, cy, lat, to, ef, ecy, ecy);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] fl, ef;
        int cy, lat, ecy;
        bit to;
        model(16'h00F0, 16'h0F00, 1'b0, ef, ecy);
        drive_op(16'h00F0, 16'h0F00, 1'b0, 1'b0, 1'b1, fl, cy, lat, to);
        n_checks++;
        if (to || fl !== ef || cy != ecy) begin
            n_fail++;
            $display("FAIL hold_result: got flags=%b cyc=%0d to=%0d expected flags=%b cyc=%0d", fl, cy, to, ef, ecy);
        end
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom); signed_mode = 1'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, a_grt, b_grt, a_eq_b, in_ready, busy} !== {1'b1, ef, 1'b0, 1'b1} ||
                int'(cmp_cycles) != ecy) begin
                n_fail++;
                $display("FAIL hold_stable_%0d: got %b cyc=%0d expected %b cyc=%0d", k,
                         {out_valid, a_grt, b_grt, a_eq_b, in_ready, busy}, cmp_cycles,
                         {1'b1, ef, 1'b0, 1'b1}, ecy);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, a_grt, b_grt, a_eq_b, in_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL release_edge: got %b expected 00000", {out_valid, a_grt, b_grt, a_eq_b, in_ready});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL release_turnaround: got %b expected 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] fl, ef;
        int cy, lat, ecy, w;
        bit to, seen;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, a_grt, b_grt, a_eq_b, cmp_cycles, busy, in_ready} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 000000000",
                     {out_valid, a_grt, b_grt, a_eq_b, cmp_cycles, busy, in_ready});
        end
        #3 rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_no_result: got out_valid=1 expected 0");
        end
        model(16'h0001, 16'h0002, 1'b0, ef, ecy);
        drive_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, fl, cy, lat, to);
        n_checks++;
        if (to || fl !== ef || fl !== 3'b010 || cy != ecy || lat != ecy) begin
            n_fail++;
            $display("FAIL after_reset_op: got flags=%b cyc=%0d lat=%0d to=%0d expected flags=%b cyc=%0d",
                     fl, cy, lat, to, ef, ecy);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, mask;
        logic [2:0] fl, ef;
        int cy, lat, ecy, k;
        bit to, s, pr;
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            k  = int'($urandom_range(0, NC));
            mask = (k == NC) ? {W{1'b1}} : ~({W{1'b1}} >> (k * C));
            rb = (ra & mask) | (W'($urandom) & ~mask);
            s  = 1'($urandom);
            pr = 1'($urandom);
            model(ra, rb, s, ef, ecy);
            drive_op(ra, rb, s, pr, 1'b0, fl, cy, lat, to);
            n_checks++;
            if (to || fl !== ef || cy != ecy || lat != ecy) begin
                n_fail++;
                $display("FAIL random_%0d a=%h b=%h s=%0d: got flags=%b cyc=%0d lat=%0d to=%0d expected flags=%b cyc=%0d",
                         i, ra, rb, s, fl, cy, lat, to, ef, ecy);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] fl, ef;
        int cy, lat, ecy;
        bit to;
        logic [W-1:0] ra, rb;
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            model(ra, rb, 1'b1, ef, ecy);
            drive_op(ra, rb, 1'b1, 1'b0, 1'b0, fl, cy, lat, to);
            n_checks++;
            if (to || fl !== ef || cy != ecy || {out_valid, in_ready} !== 2'b00) begin
                n_fail++;
                $display("FAIL b2b_%0d: got flags=%b cyc=%0d ov/ir=%b expected flags=%b cyc=%0d ov/ir=00",
                         i, fl, cy, {out_valid, in_ready}, ef, ecy);
            end
            @(posedge clk); #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b expected 1", i, in_ready);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
